// File: rtl/mcp4728_update_scheduler.sv
// mcp4728_update_scheduler
// Shares one MCP4728 I2C driver between up to four devices (selected by the
// driver's LDAC index). Keeps a 4x4 shadow file of 12-bit codes, tracks which
// devices hold unsent values, serves them round-robin one driver pass at a
// time, freezes the driver's inputs for the whole pass and watchdogs the
// driver so a hung pass is aborted and retried.
module mcp4728_update_scheduler #(
  parameter int TIMEOUT_CYC = 8192,
  parameter int GAP_CYC     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        wr_en_i,
  input  logic [1:0]  wr_dev_i,
  input  logic [1:0]  wr_ch_i,
  input  logic [11:0] wr_data_i,
  input  logic        force_all_i,
  input  logic        err_clr_i,
  input  logic [4:0]  drv_state_i,
  output logic [11:0] drv_dac0_o,
  output logic [11:0] drv_dac1_o,
  output logic [11:0] drv_dac2_o,
  output logic [11:0] drv_dac3_o,
  output logic [2:0]  drv_dac_number_o,
  output logic        drv_need_transmit_o,
  output logic        busy_o,
  output logic [1:0]  cur_dev_o,
  output logic [3:0]  pending_o,
  output logic        timeout_err_o
);

  // state  | meaning
  // -------+-----------------------------------------------------------------
  // IDLE   | waiting for enable and at least one dirty device
  // LAUNCH | snapshot presented, start request held until driver leaves idle
  // RUN    | driver pass in progress, waiting for it to return to idle
  // GAP    | enforced idle spacing before the next pass may be launched
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  // Watchdog and gap timers are down-counters loaded with (length - 1) and
  // expiring on the terminal count of zero.
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

  state_e                 state_q, state_d;
  logic [3:0]             pending_q, pending_d;
  logic [3:0][11:0]       dac_q, dac_d;
  logic [1:0]             dac_num_q, dac_num_d;
  logic                   nt_q, nt_d;
  logic [1:0]             cur_dev_q, cur_dev_d;
  logic [WD_W-1:0]        wd_q, wd_d, wd_dec;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   err_q, err_d;
  logic [3:0][3:0][11:0]  shadow_q;

  logic                   sel_found;
  logic [1:0]             sel_dev;
  logic                   expire;

  assign drv_dac0_o          = dac_q[0];
  assign drv_dac1_o          = dac_q[1];
  assign drv_dac2_o          = dac_q[2];
  assign drv_dac3_o          = dac_q[3];
  assign drv_dac_number_o    = {1'b0, dac_num_q};
  assign drv_need_transmit_o = nt_q;
  assign busy_o              = (state_q != ST_IDLE);
  assign cur_dev_o           = cur_dev_q;
  assign pending_o           = pending_q;
  assign timeout_err_o       = err_q;

  // Saturating decrement so a late LAUNCH->RUN hand-off cannot wrap the timer.
  assign wd_dec = (wd_q != '0) ? (wd_q - 1'b1) : '0;

  // Round-robin pick: scan from the device after the last one served, wrapping
  // back to it last.
  always_comb begin
    sel_found = 1'b0;
    sel_dev   = cur_dev_q;
    for (int i = 1; i <= 4; i++) begin
      if (!sel_found && pending_q[cur_dev_q + 2'(i)]) begin
        sel_found = 1'b1;
        sel_dev   = cur_dev_q + 2'(i);
      end
    end
  end

  // Shadow register file: writes land every cycle regardless of FSM state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
    end else if (wr_en_i) begin
      shadow_q[wr_dev_i][wr_ch_i] <= wr_data_i;
    end
  end

  // Next-state logic for the pass sequencer, dirty mask and error flag.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    dac_d     = dac_q;
    dac_num_d = dac_num_q;
    nt_d      = nt_q;
    cur_dev_d = cur_dev_q;
    wd_d      = wd_q;
    gap_d     = gap_q;
    err_d     = err_q;
    expire    = 1'b0;

    if (err_clr_i) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (enable_i && sel_found) begin
          state_d            = ST_LAUNCH;
          cur_dev_d          = sel_dev;
          dac_num_d          = sel_dev;
          dac_d              = shadow_q[sel_dev];
          pending_d[sel_dev] = 1'b0;
          nt_d               = 1'b1;
          wd_d               = WD_LOAD;
        end
      end
      ST_LAUNCH: begin
        // Drop the request on the same edge the driver is seen busy so it
        // cannot start a second pass.
        if (drv_state_i != '0) begin
          nt_d    = 1'b0;
          state_d = ST_RUN;
          wd_d    = wd_dec;
        end else if (wd_q == '0) begin
          expire = 1'b1;
        end else begin
          wd_d = wd_dec;
        end
      end
      ST_RUN: begin
        if (drv_state_i == '0) begin
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end else if (wd_q == '0) begin
          expire = 1'b1;
        end else begin
          wd_d = wd_dec;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
    endcase

    // Hung driver: flag it, abandon the pass and requeue the device.
    if (expire) begin
      err_d                = 1'b1;
      pending_d[cur_dev_q] = 1'b1;
      nt_d                 = 1'b0;
      state_d              = ST_GAP;
      gap_d                = GAP_LOAD;
    end

    // New dirtiness is applied last so it overrides the selection clear.
    if (force_all_i) begin
      pending_d = 4'b1111;
    end
    if (wr_en_i) begin
      pending_d[wr_dev_i] = 1'b1;
    end
  end

  // Sequencer state register; reset aborts any pass immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      dac_q     <= '0;
      dac_num_q <= '0;
      nt_q      <= 1'b0;
      cur_dev_q <= 2'd3;
      wd_q      <= '0;
      gap_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      dac_q     <= dac_d;
      dac_num_q <= dac_num_d;
      nt_q      <= nt_d;
      cur_dev_q <= cur_dev_d;
      wd_q      <= wd_d;
      gap_q     <= gap_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_mcp4728_update_scheduler.sv
// Testbench for mcp4728_update_scheduler: a simple MCP4728 driver model, a
// launch logger and one task per scenario checked against a shadow-file model.
module tb_mcp4728_update_scheduler;

  localparam int TIMEOUT_CYC = 8192;
  localparam int GAP_CYC     = 4;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        wr_en;
  logic [1:0]  wr_dev;
  logic [1:0]  wr_ch;
  logic [11:0] wr_data;
  logic        force_all;
  logic        err_clr;
  logic [4:0]  drv_state;
  logic [11:0] dac0, dac1, dac2, dac3;
  logic [2:0]  dac_num;
  logic        nt;
  logic        busy;
  logic [1:0]  cur_dev;
  logic [3:0]  pending;
  logic        terr;
  logic [47:0] dac_all;

  assign dac_all = {dac3, dac2, dac1, dac0};

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] mdl [4][4];
  int          log_dev[$];
  logic [47:0] log_val[$];

  int drv_delay = 2;
  int drv_len   = 10;
  bit drv_dead  = 1'b0;
  int dly       = 0;
  int run       = 0;

  mcp4728_update_scheduler #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .GAP_CYC    (GAP_CYC)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .enable_i           (enable),
    .wr_en_i            (wr_en),
    .wr_dev_i           (wr_dev),
    .wr_ch_i            (wr_ch),
    .wr_data_i          (wr_data),
    .force_all_i        (force_all),
    .err_clr_i          (err_clr),
    .drv_state_i        (drv_state),
    .drv_dac0_o         (dac0),
    .drv_dac1_o         (dac1),
    .drv_dac2_o         (dac2),
    .drv_dac3_o         (dac3),
    .drv_dac_number_o   (dac_num),
    .drv_need_transmit_o(nt),
    .busy_o             (busy),
    .cur_dev_o          (cur_dev),
    .pending_o          (pending),
    .timeout_err_o      (terr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver model: starts drv_delay cycles after seeing the request, stays busy
  // drv_len cycles, then returns to idle. drv_dead keeps it stuck in idle.
  always @(posedge clk) begin
    if (rst || drv_dead) begin
      drv_state <= 5'd0;
      dly       <= 0;
      run       <= 0;
    end else if (drv_state == 5'd0) begin
      if (nt) begin
        if (dly + 1 >= drv_delay) begin
          drv_state <= 5'd1;
          run       <= drv_len;
          dly       <= 0;
        end else begin
          dly <= dly + 1;
        end
      end else begin
        dly <= 0;
      end
    end else begin
      if (run <= 1) begin
        drv_state <= 5'd0;
      end else begin
        run       <= run - 1;
        drv_state <= 5'd2;
      end
    end
  end

  // Launch logger and snapshot-hold monitor.
  bit          prev_nt   = 1'b0;
  bit          prev_busy = 1'b0;
  logic [50:0] prev_snap = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_nt   = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (nt && !prev_nt) begin
        log_dev.push_back(int'(dac_num[1:0]));
        log_val.push_back(dac_all);
      end
      if (busy && prev_busy) begin
        n_cmp++;
        if ({dac_num, dac_all} !== prev_snap) begin
          n_err++;
          $display("FAIL snapshot_hold: got %h required %h", {dac_num, dac_all}, prev_snap);
        end
      end
      prev_nt   = nt;
      prev_busy = busy;
      prev_snap = {dac_num, dac_all};
    end
  end

  function automatic logic [47:0] mdl_vec(input int d);
    return {mdl[d][3], mdl[d][2], mdl[d][1], mdl[d][0]};
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 4; c++)
        mdl[d][c] = 12'h000;
    log_dev.delete();
    log_val.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_dev = 2'd0; wr_ch = 2'd0;
    wr_data = 12'h000; force_all = 1'b0; err_clr = 1'b0; drv_dead = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_model();
    @(negedge clk);
  endtask

  task automatic do_write(input int d, input int c, input logic [11:0] v);
    wr_en = 1'b1; wr_dev = 2'(d); wr_ch = 2'(c); wr_data = v;
    @(negedge clk);
    wr_en = 1'b0;
    mdl[d][c] = v;
  endtask

  task automatic wait_drain(input int max_cyc, output bit ok);
    int k = 0;
    while ((busy || pending != 4'd0) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    ok = !(busy || pending != 4'd0);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({dac_all, dac_num, nt, busy, pending, terr} !== 58'd0) begin
      n_err++;
      $display("FAIL reset_zero: got %h required 0", {dac_all, dac_num, nt, busy, pending, terr});
    end
    n_cmp++;
    if (cur_dev !== 2'd3) begin
      n_err++;
      $display("FAIL reset_cur_dev: got %0d required 3", cur_dev);
    end
  endtask

  task automatic test_single();
    int k, nt_cnt, ret_k;
    bit seen_run;
    drv_delay = 2; drv_len = 500; enable = 1'b1;
    do_write(1, 2, 12'hABC);
    k = 0;
    while (!busy && k < 20) begin @(negedge clk); k++; end
    n_cmp++;
    if (k !== 1) begin n_err++; $display("FAIL single_latency: got %0d cycles required 1", k); end
    n_cmp++;
    if (dac_num !== 3'd1) begin n_err++; $display("FAIL single_dac_number: got %0d required 1", dac_num); end
    n_cmp++;
    if (dac2 !== 12'hABC) begin n_err++; $display("FAIL single_dac2: got %h required abc", dac2); end
    n_cmp++;
    if (pending !== 4'd0) begin n_err++; $display("FAIL single_pending: got %b required 0000", pending); end
    nt_cnt = 0; ret_k = -1; seen_run = 1'b0; k = 0;
    while (busy && k < 2000) begin
      if (nt) nt_cnt++;
      if (drv_state != 5'd0) seen_run = 1'b1;
      else if (seen_run && ret_k < 0) ret_k = k;
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (nt_cnt !== 3) begin n_err++; $display("FAIL single_nt_width: got %0d required 3", nt_cnt); end
    n_cmp++;
    if (busy !== 1'b0 || ret_k < 0 || (k - ret_k) !== GAP_CYC + 1) begin
      n_err++;
      $display("FAIL single_gap: got %0d required %0d", k - ret_k, GAP_CYC + 1);
    end
  endtask

  task automatic test_force_order();
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    int k;
    bit ok;
    do_reset();
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 4; c++)
        do_write(d, c, 12'($urandom_range(0, 4095)));
    drv_delay = 1; drv_len = 10;
    log_dev.delete(); log_val.delete();
    enable = 1'b1; force_all = 1'b1;
    @(negedge clk);
    force_all = 1'b0;
    k = 0;
    while (log_dev.size() < 2 && k < 500) begin @(negedge clk); k++; end
    while (drv_state == 5'd0 && k < 500) begin @(negedge clk); k++; end
    while (drv_state != 5'd0 && k < 500) begin @(negedge clk); k++; end
    force_all = 1'b1;
    @(negedge clk);
    force_all = 1'b0;
    wait_drain(2000, ok);
    n_cmp++;
    if (!ok || log_dev.size() !== 6) begin
      n_err++;
      $display("FAIL force_count: got %0d passes required 6", log_dev.size());
    end
    for (int i = 0; i < 6 && i < log_dev.size(); i++) begin
      n_cmp++;
      if (log_dev[i] !== exp_order[i]) begin
        n_err++;
        $display("FAIL force_order[%0d]: got dev %0d required %0d", i, log_dev[i], exp_order[i]);
      end
      n_cmp++;
      if (log_val[i] !== mdl_vec(exp_order[i])) begin
        n_err++;
        $display("FAIL force_data[%0d]: got %h required %h", i, log_val[i], mdl_vec(exp_order[i]));
      end
    end
  endtask

  task automatic test_write_during_run();
    logic [11:0] old_v;
    int k;
    bit ok;
    drv_delay = 2; drv_len = 30; enable = 1'b1;
    log_dev.delete(); log_val.delete();
    old_v = 12'($urandom_range(0, 4095));
    if (old_v == 12'h123) old_v = 12'h321;
    do_write(0, 0, old_v);
    k = 0;
    while (drv_state == 5'd0 && k < 50) begin @(negedge clk); k++; end
    do_write(0, 0, 12'h123);
    n_cmp++;
    if (pending[0] !== 1'b1) begin n_err++; $display("FAIL wrun_pending: got %b required bit0 set", pending); end
    k = 0;
    while (busy && k < 200) begin
      n_cmp++;
      if (dac0 !== old_v) begin n_err++; $display("FAIL wrun_hold: got %h required %h", dac0, old_v); end
      @(negedge clk);
      k++;
    end
    k = 0;
    while (log_dev.size() < 2 && k < 50) begin @(negedge clk); k++; end
    n_cmp++;
    if (log_dev.size() < 2 || log_dev[1] !== 0 || log_val[1] !== mdl_vec(0)) begin
      n_err++;
      $display("FAIL wrun_second_pass: got %0d passes, last %h required dev0 %h", log_dev.size(),
               (log_val.size() > 0) ? log_val[log_val.size()-1] : 48'd0, mdl_vec(0));
    end
    wait_drain(500, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL wrun_drain: got busy %b pending %b required idle", busy, pending); end
  endtask

  task automatic test_timeout();
    int k;
    bit ok;
    drv_delay = 2; drv_len = 5; enable = 1'b1;
    log_dev.delete(); log_val.delete();
    drv_dead = 1'b1; err_clr = 1'b1;
    do_write(2, 1, 12'($urandom_range(0, 4095)));
    k = 0;
    while (!busy && k < 10) begin @(negedge clk); k++; end
    k = 0;
    while (!terr && k < TIMEOUT_CYC + 100) begin @(negedge clk); k++; end
    n_cmp++;
    if (k !== TIMEOUT_CYC) begin n_err++; $display("FAIL timeout_cycles: got %0d required %0d", k, TIMEOUT_CYC); end
    n_cmp++;
    if (pending[2] !== 1'b1 || nt !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_requeue: got pending %b nt %b required bit2 set nt 0", pending, nt);
    end
    err_clr = 1'b0; drv_dead = 1'b0;
    k = 0;
    while (log_dev.size() < 2 && k < GAP_CYC + 20) begin @(negedge clk); k++; end
    n_cmp++;
    if (log_dev.size() < 2 || log_dev[1] !== 2 || log_val[1] !== mdl_vec(2)) begin
      n_err++;
      $display("FAIL timeout_retry: got %0d passes required retry of dev2", log_dev.size());
    end
    wait_drain(500, ok);
    n_cmp++;
    if (!ok || terr !== 1'b1) begin n_err++; $display("FAIL timeout_sticky: got %b required 1", terr); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_cmp++;
    if (terr !== 1'b0) begin n_err++; $display("FAIL timeout_clear: got %b required 0", terr); end
  endtask

  task automatic test_reset_mid();
    int k, n_launch;
    drv_delay = 2; drv_len = 200; enable = 1'b1;
    do_write(3, 0, 12'($urandom_range(0, 4095)));
    k = 0;
    while (drv_state == 5'd0 && k < 50) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({dac_all, dac_num, nt, busy, pending, terr} !== 58'd0 || cur_dev !== 2'd3) begin
      n_err++;
      $display("FAIL reset_mid: got %h cur %0d required 0 cur 3",
               {dac_all, dac_num, nt, busy, pending, terr}, cur_dev);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    n_launch = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || nt) n_launch++;
    end
    n_cmp++;
    if (n_launch !== 0) begin n_err++; $display("FAIL reset_mid_no_launch: got %0d busy cycles required 0", n_launch); end
  endtask

  task automatic test_enable_gate();
    int k, busy_cnt;
    bit seen_drv;
    drv_delay = 2; drv_len = 8; enable = 1'b0;
    do_write(0, 3, 12'($urandom_range(0, 4095)));
    do_write(2, 0, 12'($urandom_range(0, 4095)));
    n_cmp++;
    if (pending !== 4'b0101) begin n_err++; $display("FAIL gate_pending: got %b required 0101", pending); end
    busy_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || nt) busy_cnt++;
    end
    n_cmp++;
    if (busy_cnt !== 0) begin n_err++; $display("FAIL gate_hold: got %0d busy cycles required 0", busy_cnt); end
    enable = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (nt !== 1'b1 || dac_num !== 3'd0 || dac_all !== mdl_vec(0)) begin
      n_err++;
      $display("FAIL gate_launch: got nt %b dev %0d data %h required 1 0 %h", nt, dac_num, dac_all, mdl_vec(0));
    end
    enable = 1'b0;
    seen_drv = 1'b0; k = 0;
    while (busy && k < 100) begin
      if (drv_state != 5'd0) seen_drv = 1'b1;
      @(negedge clk);
      k++;
    end
    busy_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || nt) busy_cnt++;
    end
    n_cmp++;
    if (!seen_drv || busy_cnt !== 0 || pending !== 4'b0100) begin
      n_err++;
      $display("FAIL gate_fall: got drv %b busy %0d pending %b required 1 0 0100", seen_drv, busy_cnt, pending);
    end
    enable = 1'b1;
  endtask

  task automatic test_random();
    bit written[4];
    bit ok;
    int last;
    do_reset();
    for (int d = 0; d < 4; d++) written[d] = 1'b0;
    drv_delay = $urandom_range(1, 3);
    drv_len   = $urandom_range(2, 30);
    enable = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      wr_en     = ($urandom_range(0, 3) == 0);
      wr_dev    = 2'($urandom_range(0, 3));
      wr_ch     = 2'($urandom_range(0, 3));
      wr_data   = 12'($urandom_range(0, 4095));
      force_all = ($urandom_range(0, 99) == 0);
      enable    = ($urandom_range(0, 9) != 0);
      @(negedge clk);
      if (wr_en) begin
        mdl[wr_dev][wr_ch] = wr_data;
        written[wr_dev] = 1'b1;
      end
    end
    wr_en = 1'b0; force_all = 1'b0; enable = 1'b1;
    wait_drain(5000, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL random_drain: got busy %b pending %b required idle", busy, pending); end
    for (int d = 0; d < 4; d++) begin
      last = -1;
      for (int i = 0; i < log_dev.size(); i++)
        if (log_dev[i] == d) last = i;
      if (written[d]) begin
        n_cmp++;
        if (last < 0 || log_val[last] !== mdl_vec(d)) begin
          n_err++;
          $display("FAIL random_final[%0d]: got %h required %h", d,
                   (last < 0) ? 48'd0 : log_val[last], mdl_vec(d));
        end
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_force_order();
    test_write_during_run();
    test_timeout();
    test_reset_mid();
    test_enable_gate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mcp4728_update_scheduler.md
Name: mcp4728_update_scheduler

Overview:
- Sits in front of the MCP4728 I2C driver and shares it between up to four MCP4728 devices, selected by the driver's per-device LDAC lines.
- Holds a 4-device x 4-channel shadow register file of 12-bit codes and tracks which devices have changed values.
- Picks one dirty device at a time (round-robin) and runs exactly one driver pass for it.
- Holds the driver's DAC inputs stable for the whole pass and watchdogs the driver for hangs.

Parameters:
- TIMEOUT_CYC, 8192: clk cycles allowed from launch until the driver returns to idle before the pass is aborted.
- GAP_CYC, 4: idle clk cycles inserted between consecutive passes; minimum 1.

Ports:
- clk  in  1  system clock; same clock as the driver.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  when 1, the scheduler may launch new passes.
- wr_en  in  1  write strobe into the shadow register file.
- wr_dev  in  2  device index for the write.
- wr_ch  in  2  channel index for the write.
- wr_data  in  12  DAC code for the write.
- force_all  in  1  single-cycle pulse; marks all 4 devices dirty.
- err_clr  in  1  clears timeout_err.
- drv_state  in  5  driver state register; 0 = idle.
- drv_dac0..drv_dac3  out  12 each  channel codes presented to the driver.
- drv_dac_number  out  3  LDAC index presented to the driver; upper bit always 0.
- drv_need_transmit  out  1  start request to the driver.
- busy  out  1  high whenever the FSM is not in IDLE.
- cur_dev  out  2  device of the current or most recent pass.
- pending  out  4  dirty mask, one bit per device.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (async), all outputs and internal state:
  - shadow registers = 0, pending = 0, drv_dac* = 0, drv_dac_number = 0
  - drv_need_transmit = 0, busy = 0, cur_dev = 3 (so device 0 is served first)
  - timeout_err = 0, FSM = IDLE
  - reset mid-pass aborts immediately with no cleanup.
- Writes:
  - Accepted every cycle in every state.
  - shadow[wr_dev][wr_ch] <= wr_data.
  - pending[wr_dev] <= 1 on the next edge.
- force_all: pending <= 4'b1111.
- Round-robin: search starts at (cur_dev+1) mod 4 and wraps; the first set pending bit wins.
- FSM states:
  - IDLE: if enable && pending != 0 →
    - select device d; cur_dev <= d; drv_dac_number <= {1'b0, d}
    - drv_dac0..3 <= shadow[d][0..3] (snapshot)
    - pending[d] <= 0; drv_need_transmit <= 1; watchdog <= 0
    - next state LAUNCH.
  - LAUNCH: hold drv_need_transmit = 1 until drv_state != 0.
    - Then drv_need_transmit <= 0 on that same edge, so the driver makes exactly one pass.
    - Next state RUN.
  - RUN: wait for drv_state == 0, then go to GAP.
  - GAP: count GAP_CYC cycles, then go to IDLE.
- Snapshot hold: drv_dac* and drv_dac_number change only on the IDLE→LAUNCH edge; they are stable through LAUNCH, RUN and GAP.
- Watchdog:
  - Counts in LAUNCH and RUN.
  - On reaching TIMEOUT_CYC: timeout_err <= 1; pending[cur_dev] <= 1 (retry); drv_need_transmit <= 0; go to GAP.
- Simultaneous events:
  - Write to device d on the cycle d is selected: the snapshot takes the old value and pending[d] stays 1 (the write wins over the clear).
  - force_all on the selection cycle: all bits end up 1.
  - err_clr and a timeout on the same cycle: timeout_err ends at 1 (the set wins).
- enable falling mid-pass: the current pass completes normally; no new launch is made.
- Latency, IDLE with pending to drv_need_transmit high: 1 cycle.
- busy = (state != IDLE).

Test Plan:
- Reset, write dev1 ch2 = 12'hABC, enable = 1; driver model goes nonzero 2 cycles after request and stays busy 500 cycles → drv_need_transmit high for exactly 3 cycles, drv_dac_number = 1, drv_dac2 = 12'hABC, pending = 0 after selection, busy drops GAP_CYC+1 cycles after the driver returns to 0.
- force_all with enable = 1 → passes run in device order 0,1,2,3; a second force_all after the pass for device 1 → order continues 2,3,0,1.
- Write dev0 ch0 = 12'h123 while dev0's pass is in RUN → drv_dac0 stays at the old value until GAP ends; pending[0] = 1; a second pass for dev0 follows with 12'h123.
- Driver model never leaves 0 → timeout_err = 1 after TIMEOUT_CYC cycles, pending bit restored, FSM retries; err_clr then clears timeout_err.
- Assert rst during RUN → all outputs equal their reset values in the same cycle; after release with pending = 0, no launch occurs.
- enable = 0 with pending = 4'b0101 → no launch; raise enable → dev0 is launched 1 cycle later.
